// File: rtl/inp_cond.sv
// Input conditioning for the game core: synchronize raw controls, debounce on a
// 1 ms tick, and shape each coin switch into fixed-width pulses with a queue.

// Per-coin pulse shaper: one PULSE of COIN_MS ticks, then GAP_MS ticks idle,
// with up to three further presses remembered while busy.
module inp_cond_coin #(
  parameter int COIN_MS = 40,
  parameter int GAP_MS  = 80
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic rise_i,
  output logic act_o,
  output logic done_o
);
  localparam int TMAX = (COIN_MS > GAP_MS) ? COIN_MS : GAP_MS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} st_e;

  st_e           state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [1:0]    p_q, p_d, p_inc;

  // state, timer and pending-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      p_q     <= p_d;
    end
  end

  // next state; a press seen in the expiry cycle is queued before the P test
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    p_d     = p_q;
    done_o  = 1'b0;
    p_inc   = p_q + {1'b0, (rise_i && state_q != IDLE && p_q != 2'd3)};
    case (state_q)
      IDLE: begin
        if (rise_i) begin
          state_d = PULSE;
          t_d     = '0;
        end
      end
      PULSE: begin
        p_d = p_inc;
        if (tick_i) begin
          if (t_q == TW'(COIN_MS - 1)) begin
            state_d = GAP;
            t_d     = '0;
            done_o  = 1'b1;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      GAP: begin
        p_d = p_inc;
        if (tick_i) begin
          if (t_q == TW'(GAP_MS - 1)) begin
            t_d = '0;
            if (p_inc != 2'd0) begin
              p_d     = p_inc - 2'd1;
              state_d = PULSE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign act_o = (state_q == PULSE);
endmodule

module inp_cond #(
  parameter int TICK_DIV = 14318,
  parameter int DB_MS    = 5,
  parameter int COIN_MS  = 40,
  parameter int GAP_MS   = 80
) (
  input  logic        MCLK,
  input  logic        RESET_N,
  input  logic [10:0] RAW,
  output logic [10:0] INP,
  output logic        TICK,
  output logic [15:0] COIN_TOTAL
);
  localparam int NB = 11;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DB_MS + 1);

  logic [NB-1:0]         s1_q, s2_q;
  logic [PW-1:0]         pre_q, pre_d;
  logic                  tick_q;
  logic [NB-1:0]         db_q;
  logic [NB-1:0][CW-1:0] db_c_q;
  logic [1:0]            coin_rise, coin_act, coin_done;
  logic [10:0]           inp_q;
  logic [15:0]           total_q;

  // two-flop synchronizer on every raw input
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= RAW;
      s2_q <= s1_q;
    end
  end

  // prescaler wraps at TICK_DIV-1; tick is registered to coincide with that count
  always_comb begin
    pre_d = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + PW'(1);
  end

  // prescaler and tick registers
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= (pre_d == PW'(TICK_DIV - 1));
    end
  end

  // per-bit debounce: state follows input only after DB_MS stable ticks
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      db_q   <= '0;
      db_c_q <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (s2_q[i] == db_q[i]) begin
          db_c_q[i] <= '0;
        end else if (tick_q) begin
          if (db_c_q[i] == CW'(DB_MS - 1)) begin
            db_q[i]   <= s2_q[i];
            db_c_q[i] <= '0;
          end else begin
            db_c_q[i] <= db_c_q[i] + CW'(1);
          end
        end
      end
    end
  end

  // debounced 0->1 coin edge, flagged in the same tick cycle the state flips
  always_comb begin
    for (int k = 0; k < 2; k++)
      coin_rise[k] = tick_q && s2_q[8+k] && !db_q[8+k] &&
                     (db_c_q[8+k] == CW'(DB_MS - 1));
  end

  for (genvar k = 0; k < 2; k++) begin : g_coin
    inp_cond_coin #(.COIN_MS(COIN_MS), .GAP_MS(GAP_MS)) u_coin (
      .clk    (MCLK),
      .rst_n  (RESET_N),
      .tick_i (tick_q),
      .rise_i (coin_rise[k]),
      .act_o  (coin_act[k]),
      .done_o (coin_done[k])
    );
  end

  // active-low output register and combined coin counter
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      inp_q   <= 11'h7FF;
      total_q <= '0;
    end else begin
      inp_q   <= ~{db_q[10], coin_act[1], coin_act[0], db_q[7:0]};
      total_q <= total_q + {15'd0, coin_done[0]} + {15'd0, coin_done[1]};
    end
  end

  assign INP        = inp_q;
  assign TICK       = tick_q;
  assign COIN_TOTAL = total_q;
endmodule

// File: tb/tb_inp_cond.sv
// Directed bench for inp_cond: TICK_DIV=4, DB_MS=3, COIN_MS=2, GAP_MS=2 on the
// main instance; a second instance with a long gap exercises the press queue.
module tb_inp_cond;
  logic        MCLK = 1'b0;
  logic        RESET_N;
  logic [10:0] RAW, RAW2, INP, INP2;
  logic        TICK, TICK2;
  logic [15:0] TOT, TOT2;

  int n_chk = 0;
  int n_err = 0;

  always #5 MCLK = ~MCLK;

  inp_cond #(.TICK_DIV(4), .DB_MS(3), .COIN_MS(2), .GAP_MS(2)) u_dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .RAW(RAW), .INP(INP), .TICK(TICK), .COIN_TOTAL(TOT)
  );

  inp_cond #(.TICK_DIV(4), .DB_MS(3), .COIN_MS(2), .GAP_MS(40)) u_dut2 (
    .MCLK(MCLK), .RESET_N(RESET_N), .RAW(RAW2), .INP(INP2), .TICK(TICK2), .COIN_TOTAL(TOT2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  // raise mask, drop it after 'hold' cycles, observe bit b of INP for ncyc cycles
  task automatic watch(input int hold, input int ncyc, input logic [10:0] mask, input int b,
                       output int lows, output int falls, output int maxstep, output int misal);
    logic        prev;
    logic [15:0] ptot, step;
    lows = 0; falls = 0; maxstep = 0; misal = 0;
    prev = INP[b];
    ptot = TOT;
    RAW  = RAW | mask;
    for (int i = 0; i < ncyc; i++) begin
      cyc(1);
      if (!INP[b]) lows++;
      if (prev && !INP[b]) falls++;
      step = TOT - ptot;
      if (int'(step) > maxstep) maxstep = int'(step);
      if (INP[8] != INP[9]) misal++;
      prev = INP[b];
      ptot = TOT;
      if (i == hold - 1) RAW = RAW & ~mask;
    end
  endtask

  initial begin
    int first, cnt, lat, lows, falls, maxstep, misal, w;
    int ft[$];
    logic prev;

    RESET_N = 1'b0;
    RAW = '0;
    RAW2 = '0;
    cyc(3);
    chk("rst_inp", INP, 11'h7FF);
    chk("rst_tick", TICK, 1'b0);
    chk("rst_total", TOT, 16'h0);
    chk("rst_tick2", TICK2, 1'b0);
    RESET_N = 1'b1;

    // first tick on the third edge after release, then every 4 cycles
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (TICK && first == 0) first = i;
    end
    chk("tick_first", first, 3);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (TICK) cnt++;
    end
    chk("tick_count40", cnt, 10);

    // 2-tick glitch must not move the debounced state
    RAW[0] = 1'b1;
    cyc(8);
    RAW[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (!INP[0]) cnt++;
    end
    chk("glitch_ignored", cnt, 0);

    // held input: 3 ticks after sync, plus output register
    RAW[0] = 1'b1;
    lat = 0;
    while (INP[0] !== 1'b0 && lat < 40) begin
      cyc(1);
      lat++;
    end
    chk("db_lat_range", (lat >= 12 && lat <= 15), 1'b1);
    chk("db_others", INP[10:1], 10'h3FF);
    RAW[0] = 1'b0;
    cyc(30);
    chk("db_release", INP[0], 1'b1);

    // single coin held 20 ticks: one 8-cycle pulse
    watch(80, 120, 11'h100, 8, lows, falls, maxstep, misal);
    chk("coin1_width", lows, 8);
    chk("coin1_pulses", falls, 1);
    chk("coin1_total", TOT, 16'd1);
    chk("coin1_step", maxstep, 1);

    // both coins together: aligned pulses, total steps by 2 at once
    watch(80, 120, 11'h300, 9, lows, falls, maxstep, misal);
    chk("sim_align", misal, 0);
    chk("sim_width", lows, 8);
    chk("sim_step", maxstep, 2);
    chk("sim_total", TOT, 16'd3);

    // reset in the middle of a pulse
    RAW[8] = 1'b1;
    w = 0;
    while (INP[8] !== 1'b0 && w < 40) begin
      cyc(1);
      w++;
    end
    chk("rstp_seen", (w < 40), 1'b1);
    cyc(2);
    RESET_N = 1'b0;
    #1;
    chk("rstp_inp", INP, 11'h7FF);
    chk("rstp_total", TOT, 16'h0);
    RAW[8] = 1'b0;
    cyc(3);
    RESET_N = 1'b1;
    watch(0, 60, 11'h000, 8, lows, falls, maxstep, misal);
    chk("rstp_nopulse", falls, 0);
    chk("rstp_total_after", TOT, 16'h0);

    // counter wrap from 0xFFFF
    force u_dut.total_q = 16'hFFFF;
    cyc(1);
    release u_dut.total_q;
    cyc(1);
    chk("wrap_preload", TOT, 16'hFFFF);
    watch(80, 120, 11'h100, 8, lows, falls, maxstep, misal);
    chk("wrap_pulses", falls, 1);
    chk("wrap_total", TOT, 16'h0000);

    // five presses during one pulse+gap on the long-gap instance: 1 + 3 queued
    prev = INP2[8];
    lows = 0;
    for (int i = 0; i < 800; i++) begin
      RAW2[8] = (i < 160) && ((i % 32) < 16);
      cyc(1);
      if (!INP2[8]) lows++;
      if (prev && !INP2[8]) ft.push_back(i);
      prev = INP2[8];
    end
    chk("queue_pulses", ft.size(), 4);
    chk("queue_width", lows, 32);
    chk("queue_spacing", (ft.size() >= 2) ? (ft[1] - ft[0]) : -1, 168);
    chk("queue_total", TOT2, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
